// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the data-memory SRAM controller.
package sram_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_LOW  = 2'd1;
  localparam state_t S_HIGH = 2'd2;
  localparam state_t S_DONE = 2'd3;

  localparam int unsigned ADDR_BASE_DEF = 1024;
  localparam int unsigned SRAM_WAIT_DEF = 3;
  localparam int unsigned SRAM_AW_DEF   = 18;
  localparam int unsigned DW            = 32;
  localparam int unsigned SRAM_DW       = 16;

endpackage

// File: rtl/sram_ctrl_if.sv
// Pipeline-side load/store handshake between the MEM stage and the SRAM controller.
interface sram_ctrl_if;
  import sram_ctrl_pkg::*;

  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] address;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ready;

  modport master (output wr_en, rd_en, address, wdata, input rdata, ready);
  modport slave  (input wr_en, rd_en, address, wdata, output rdata, ready);
endinterface

// File: rtl/sram_ctrl.sv
// Splits one 32-bit load/store into two timed 16-bit async SRAM accesses (low half, then high half).
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_BASE = ADDR_BASE_DEF,
  parameter int unsigned SRAM_WAIT = SRAM_WAIT_DEF,
  parameter int unsigned SRAM_AW   = SRAM_AW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  sram_ctrl_if.slave         bus,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);

  localparam int unsigned CW = $clog2(SRAM_WAIT + 1);
  localparam int unsigned IW = SRAM_AW - 1;

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      cnt;
  logic               op_wr;
  logic [DW-1:0]      addr_l;
  logic [DW-1:0]      wdata_l;
  logic               req;
  logic               last;
  logic [DW-1:0]      offset;
  logic [IW-1:0]      idx;
  logic               dq_oe;
  logic [SRAM_DW-1:0] dq_out;
  logic               unused_bits;

  assign req    = bus.wr_en | bus.rd_en;
  assign last   = (cnt == CW'(SRAM_WAIT - 1));
  // Word index wraps modulo the SRAM size; byte-lane bits and the upper address are dropped.
  assign offset = addr_l - DW'(ADDR_BASE);
  assign idx    = offset[2 +: IW];
  assign unused_bits = ^{offset[DW-1:IW+2], offset[1:0]};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state: each SRAM phase lasts SRAM_WAIT cycles, DONE always returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req)  state_nxt = S_LOW;
      S_LOW:   if (last) state_nxt = S_HIGH;
      S_HIGH:  if (last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Phase counter, request latches and read-data capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      op_wr     <= 1'b0;
      addr_l    <= '0;
      wdata_l   <= '0;
      bus.rdata <= '0;
    end else begin
      if ((state == S_LOW || state == S_HIGH) && !last) cnt <= cnt + CW'(1);
      else                                              cnt <= '0;
      if (state == S_IDLE && req) begin
        op_wr   <= bus.wr_en;
        addr_l  <= bus.address;
        wdata_l <= bus.wdata;
      end
      if (!op_wr && last) begin
        if (state == S_LOW)       bus.rdata[15:0]  <= SRAM_DQ;
        else if (state == S_HIGH) bus.rdata[31:16] <= SRAM_DQ;
      end
    end
  end

  // SRAM strobes, address, write data and ready decoded from state and phase count.
  always_comb begin
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = '0;
    bus.ready = 1'b0;
    case (state)
      S_IDLE: bus.ready = !req;
      S_LOW, S_HIGH: begin
        SRAM_ADDR = {idx, (state == S_HIGH)};
        dq_out    = (state == S_HIGH) ? wdata_l[31:16] : wdata_l[15:0];
        if (op_wr) begin
          // Strobe released on the last phase cycle so data is held past the WE rising edge.
          SRAM_WE_N = last;
          dq_oe     = 1'b1;
        end else begin
          SRAM_OE_N = 1'b0;
        end
      end
      S_DONE:  bus.ready = 1'b1;
      default: bus.ready = 1'b0;
    endcase
  end

  assign SRAM_DQ   = dq_oe ? dq_out : {SRAM_DW{1'bz}};
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: behavioural async SRAM plus transaction-level reference model.
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

  localparam int W  = 3;
  localparam int NW = 1 << 18;

  logic        clk = 1'b0;
  logic        rst;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        we_n, oe_n, ce_n, ub_n, lb_n;

  sram_ctrl_if bus();

  sram_ctrl #(.ADDR_BASE(1024), .SRAM_WAIT(W), .SRAM_AW(18)) dut (
    .clk(clk), .rst(rst), .bus(bus), .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
    .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [15:0] init_pat(int i);
    return 16'((i * 40503) ^ 23130);
  endfunction

  // Behavioural asynchronous SRAM: drives DQ on read, writes on WE_N rising edge.
  logic [15:0] mem [0:NW-1];
  bit          armed = 0;
  int          we_strobes = 0;
  logic [17:0] last_oe_addr = '0;

  assign sram_dq = (!oe_n && we_n) ? mem[sram_addr] : 16'hzzzz;

  always @(posedge we_n) begin
    if (armed && rst) begin
      mem[sram_addr] = sram_dq;
      we_strobes++;
    end
  end

  always @(negedge clk) if (!oe_n) last_oe_addr = sram_addr;

  // Reference model: t = cycles since the request was accepted (-1 = idle).
  logic [15:0] exp_mem [0:NW-1];
  int          t = -1;
  bit          m_w;
  int          m_lo;
  logic [31:0] m_d;
  logic [31:0] m_rdata = '0;
  int          m_writes = 0;
  int          touched[$];

  function automatic void finish_half(int h);
    if (m_w) begin
      exp_mem[m_lo + h] = (h == 1) ? m_d[31:16] : m_d[15:0];
      touched.push_back(m_lo + h);
      m_writes++;
    end else if (h == 1) begin
      m_rdata[31:16] = exp_mem[m_lo + 1];
    end else begin
      m_rdata[15:0] = exp_mem[m_lo];
    end
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      t       = -1;
      m_rdata = '0;
    end else if (t < 0) begin
      if (bus.wr_en || bus.rd_en) begin
        t    = 0;
        m_w  = bus.wr_en;
        m_d  = bus.wdata;
        m_lo = int'((((bus.address - 32'd1024) >> 2) & 32'h1FFFF) * 2);
      end
    end else if (t == 2 * W) begin
      t = -1;
    end else begin
      if (t == W - 1)     finish_half(0);
      if (t == 2 * W - 1) finish_half(1);
      t++;
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    logic [17:0] e_addr;
    logic        e_we, e_oe, e_rdy;
    logic [15:0] e_dq;
    bit          wph;
    e_addr = '0; e_we = 1'b1; e_oe = 1'b1; e_dq = '0; wph = 0;
    e_rdy  = (t == 2 * W) || (t < 0 && !(bus.wr_en || bus.rd_en));
    if (t >= 0 && t < 2 * W) begin
      e_addr = 18'(m_lo + ((t >= W) ? 1 : 0));
      if (m_w) begin
        e_we = ((t % W) == W - 1);
        wph  = 1;
        e_dq = (t >= W) ? m_d[31:16] : m_d[15:0];
      end else begin
        e_oe = 1'b0;
      end
    end
    chk("ready", 32'(bus.ready), 32'(e_rdy));
    chk("sram_addr", 32'(sram_addr), 32'(e_addr));
    chk("we_n", 32'(we_n), 32'(e_we));
    chk("oe_n", 32'(oe_n), 32'(e_oe));
    chk("rdata", bus.rdata, m_rdata);
    if (wph) chk("dq_write", 32'(sram_dq), 32'(e_dq));
    if (rst) chk("ce_ub_lb", 32'({ce_n, ub_n, lb_n}), 32'd0);
  end

  // Present a request (at posedge+1) and hold it until DONE is seen; returns freeze length and rdata.
  task automatic do_op(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                       input bit scramble, output int lowc, output logic [31:0] rd);
    bit got;
    got = 0;
    lowc = 0;
    rd = '0;
    bus.wr_en = w; bus.rd_en = r; bus.address = a; bus.wdata = d;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.ready) begin
        got = 1;
        rd  = bus.rdata;
        break;
      end
      lowc++;
      if (scramble && k == 2) begin
        bus.address = $urandom;
        bus.wdata   = $urandom;
      end
    end
    chk("op_timeout", 32'(got), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int          lowc;
    logic [31:0] rd;
    int          ws;
    logic [31:0] addr;
    int          kind;

    for (int i = 0; i < NW; i++) begin
      mem[i]     = init_pat(i);
      exp_mem[i] = init_pat(i);
    end
    mem[18'h3FE00] = 16'hA5A5; exp_mem[18'h3FE00] = 16'hA5A5;
    mem[18'h3FE01] = 16'h5A5A; exp_mem[18'h3FE01] = 16'h5A5A;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.address = '0; bus.wdata = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    armed = 1;
    chk("post_reset_ready", 32'(bus.ready), 32'd1);
    chk("post_reset_rdata", bus.rdata, 32'd0);
    idle(2);

    // Reset mid-HIGH of a store: low half lands, high half is abandoned.
    bus.wr_en = 1'b1; bus.address = 32'd1064; bus.wdata = 32'hCAFEF00D;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_pre_we", 32'(we_n), 32'd0);
    chk("abort_pre_addr", 32'(sram_addr), 32'd21);
    #1 rst = 1'b0; bus.wr_en = 1'b0;
    #1;
    chk("abort_we", 32'(we_n), 32'd1);
    chk("abort_oe", 32'(oe_n), 32'd1);
    chk("abort_addr", 32'(sram_addr), 32'd0);
    chk("abort_rdata", bus.rdata, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    #1 chk("abort_ready", 32'(bus.ready), 32'd1);
    chk("abort_low_half", 32'(mem[20]), 32'h0000F00D);
    chk("abort_high_half", 32'(mem[21]), 32'(init_pat(21)));
    @(posedge clk); #1;

    // Store then load at the base address.
    ws = we_strobes;
    do_op(1, 0, 32'd1024, 32'hDEADBEEF, 0, lowc, rd);
    chk("st_latency", 32'(lowc), 32'd7);
    chk("st_word0", 32'(mem[0]), 32'h0000BEEF);
    chk("st_word1", 32'(mem[1]), 32'h0000DEAD);
    chk("st_strobes", 32'(we_strobes - ws), 32'd2);
    idle(1);
    do_op(0, 1, 32'd1024, 32'h0, 0, lowc, rd);
    chk("ld_latency", 32'(lowc), 32'd7);
    chk("ld_rdata", rd, 32'hDEADBEEF);
    idle(1);

    // Back-to-back stores with only the DONE cycle between freezes.
    ws = we_strobes;
    do_op(1, 0, 32'd1028, 32'h11112222, 0, lowc, rd);
    chk("b2b_lat0", 32'(lowc), 32'd7);
    do_op(1, 0, 32'd1032, 32'h33334444, 0, lowc, rd);
    chk("b2b_lat1", 32'(lowc), 32'd7);
    chk("b2b_strobes", 32'(we_strobes - ws), 32'd4);
    chk("b2b_w2", 32'(mem[2]), 32'h00002222);
    chk("b2b_w3", 32'(mem[3]), 32'h00001111);
    chk("b2b_w4", 32'(mem[4]), 32'h00004444);
    chk("b2b_w5", 32'(mem[5]), 32'h00003333);
    idle(1);

    // Simultaneous store and load: the store wins.
    do_op(1, 1, 32'd1036, 32'h12345678, 0, lowc, rd);
    chk("both_w6", 32'(mem[6]), 32'h00005678);
    chk("both_w7", 32'(mem[7]), 32'h00001234);
    chk("both_rdata_held", rd, 32'hDEADBEEF);
    idle(1);

    // Load below the base wraps to the top of the SRAM.
    ws = we_strobes;
    do_op(0, 1, 32'd0, 32'h0, 0, lowc, rd);
    chk("wrap_rdata", rd, 32'h5A5AA5A5);
    chk("wrap_last_addr", 32'(last_oe_addr), 32'h0003FE01);
    chk("wrap_no_write", 32'(we_strobes - ws), 32'd0);
    idle(3);

    // Randomised traffic against the model.
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 2);
      addr = ($urandom_range(0, 3) == 0) ? $urandom : 32'd1024 + 32'(4 * $urandom_range(0, 15));
      do_op(kind != 1, kind != 0, addr, $urandom, bit'($urandom_range(0, 1)), lowc, rd);
      chk("rand_latency", 32'(lowc), 32'd7);
      idle($urandom_range(0, 2));
    end
    idle(4);

    chk("write_count", 32'(we_strobes), 32'(m_writes));
    foreach (touched[i]) chk("mem_scoreboard", 32'(mem[touched[i]]), 32'(exp_mem[touched[i]]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
